// File: rtl/sprite_overlay.sv
// sprite_overlay: 2bpp hardware cursor overlaid on a 32-bit AXI4-Stream video path
module sprite_overlay #(
    parameter int SPRITE_SIZE = 32
) (
    input  logic        s_axis_vid_aclk,
    input  logic        areset,
    input  logic [31:0] s_axis_vid_tdata,
    input  logic        s_axis_vid_tvalid,
    output logic        s_axis_vid_tready,
    input  logic        s_axis_vid_tuser,
    input  logic        s_axis_vid_tlast,
    output logic [31:0] m_axis_vid_tdata,
    output logic        m_axis_vid_tvalid,
    input  logic        m_axis_vid_tready,
    output logic        m_axis_vid_tuser,
    output logic        m_axis_vid_tlast,
    input  logic [31:0] control_data,
    input  logic [7:0]  control_op
);
    localparam int LW = $clog2(SPRITE_SIZE);
    localparam int AW = 2 * LW - 3;
    localparam int WORDS = 1 << AW;

    logic [7:0]  ctl_op_q, ctl_op_d;
    logic [31:0] ctl_data_q, ctl_data_d;
    logic [15:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic        pend_en_q, pend_en_d;
    logic [15:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic        en_q, en_d;
    logic [23:0] col1_q, col1_d, col2_q, col2_d, col3_q, col3_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic        s1_v_q, s1_v_d, s1_user_q, s1_user_d, s1_last_q, s1_last_d, s1_hit_q, s1_hit_d;
    logic [31:0] s1_data_q, s1_data_d;
    logic [2:0]  s1_n_q, s1_n_d;
    logic        s2_v_q, s2_v_d, s2_user_q, s2_user_d, s2_last_q, s2_last_d;
    logic [31:0] s2_data_q, s2_data_d;
    logic [15:0] mem_q [WORDS];
    logic [15:0] rd_q;

    logic        s1_adv, s2_adv, acc, cur_en, hit, wr_en;
    logic [15:0] px, py, cur_x, cur_y, sh;
    logic [16:0] dx, dy;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [1:0]  v;
    logic [23:0] col;
    logic [31:0] pix;

    // Handshake, position tracking, hit test and next-state for every register
    always_comb begin
        s2_adv = !s2_v_q || m_axis_vid_tready;
        s1_adv = !s1_v_q || s2_adv;
        acc = s_axis_vid_tvalid && s1_adv;
        px = s_axis_vid_tuser ? 16'd0 : x_q;
        py = s_axis_vid_tuser ? 16'd0 : y_q;
        cur_x = s_axis_vid_tuser ? pend_x_q : pos_x_q;
        cur_y = s_axis_vid_tuser ? pend_y_q : pos_y_q;
        cur_en = s_axis_vid_tuser ? pend_en_q : en_q;
        dx = {1'b0, px} - {1'b0, cur_x};
        dy = {1'b0, py} - {1'b0, cur_y};
        hit = cur_en && !dx[16] && !dy[16] && dx[15:0] < 16'(SPRITE_SIZE) && dy[15:0] < 16'(SPRITE_SIZE);
        rd_addr = {dy[LW-1:0], dx[LW-1:3]};
        wr_en = ctl_op_q == 8'd6;
        wr_addr = ctl_data_q[24 +: AW];
        sh = rd_q >> {s1_n_q, 1'b0};
        v = sh[1:0];
        col = v == 2'd1 ? col1_q : v == 2'd2 ? col2_q : col3_q;
        pix = (s1_hit_q && v != 2'd0) ? {8'h00, col} : s1_data_q;
        ctl_op_d = control_op;
        ctl_data_d = control_data;
        pend_x_d = ctl_op_q == 8'd5 ? ctl_data_q[15:0] : pend_x_q;
        pend_y_d = ctl_op_q == 8'd5 ? ctl_data_q[31:16] : pend_y_q;
        pend_en_d = ctl_op_q == 8'd8 ? ctl_data_q[0] : pend_en_q;
        col1_d = (ctl_op_q == 8'd7 && ctl_data_q[25:24] == 2'd1) ? ctl_data_q[23:0] : col1_q;
        col2_d = (ctl_op_q == 8'd7 && ctl_data_q[25:24] == 2'd2) ? ctl_data_q[23:0] : col2_q;
        col3_d = (ctl_op_q == 8'd7 && ctl_data_q[25:24] == 2'd3) ? ctl_data_q[23:0] : col3_q;
        pos_x_d = (acc && s_axis_vid_tuser) ? pend_x_q : pos_x_q;
        pos_y_d = (acc && s_axis_vid_tuser) ? pend_y_q : pos_y_q;
        en_d = (acc && s_axis_vid_tuser) ? pend_en_q : en_q;
        x_d = acc ? (s_axis_vid_tlast ? 16'd0 : px + 16'd1) : x_q;
        y_d = acc ? (s_axis_vid_tlast ? py + 16'd1 : py) : y_q;
        s1_v_d = s1_adv ? s_axis_vid_tvalid : s1_v_q;
        s1_data_d = acc ? s_axis_vid_tdata : s1_data_q;
        s1_user_d = acc ? s_axis_vid_tuser : s1_user_q;
        s1_last_d = acc ? s_axis_vid_tlast : s1_last_q;
        s1_hit_d = acc ? hit : s1_hit_q;
        s1_n_d = acc ? dx[2:0] : s1_n_q;
        s2_v_d = s2_adv ? s1_v_q : s2_v_q;
        s2_data_d = (s2_adv && s1_v_q) ? pix : s2_data_q;
        s2_user_d = (s2_adv && s1_v_q) ? s1_user_q : s2_user_q;
        s2_last_d = (s2_adv && s1_v_q) ? s1_last_q : s2_last_q;
    end

    // Control, shadow, counter and pipeline registers
    always_ff @(posedge s_axis_vid_aclk) begin
        if (areset) begin
            ctl_op_q <= '0;
            ctl_data_q <= '0;
            pend_x_q <= '0;
            pend_y_q <= '0;
            pend_en_q <= 1'b0;
            pos_x_q <= '0;
            pos_y_q <= '0;
            en_q <= 1'b0;
            col1_q <= '0;
            col2_q <= '0;
            col3_q <= '0;
            x_q <= '0;
            y_q <= '0;
            s1_v_q <= 1'b0;
            s1_data_q <= '0;
            s1_user_q <= 1'b0;
            s1_last_q <= 1'b0;
            s1_hit_q <= 1'b0;
            s1_n_q <= '0;
            s2_v_q <= 1'b0;
            s2_data_q <= '0;
            s2_user_q <= 1'b0;
            s2_last_q <= 1'b0;
        end else begin
            ctl_op_q <= ctl_op_d;
            ctl_data_q <= ctl_data_d;
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
            pend_en_q <= pend_en_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            en_q <= en_d;
            col1_q <= col1_d;
            col2_q <= col2_d;
            col3_q <= col3_d;
            x_q <= x_d;
            y_q <= y_d;
            s1_v_q <= s1_v_d;
            s1_data_q <= s1_data_d;
            s1_user_q <= s1_user_d;
            s1_last_q <= s1_last_d;
            s1_hit_q <= s1_hit_d;
            s1_n_q <= s1_n_d;
            s2_v_q <= s2_v_d;
            s2_data_q <= s2_data_d;
            s2_user_q <= s2_user_d;
            s2_last_q <= s2_last_d;
        end
    end

    // Bitmap RAM: synchronous read-first port; the read word is held while S1 stalls
    always_ff @(posedge s_axis_vid_aclk) begin
        if (wr_en) mem_q[wr_addr] <= ctl_data_q[15:0];
        if (acc) rd_q <= mem_q[rd_addr];
    end

    assign s_axis_vid_tready = s1_adv;
    assign m_axis_vid_tvalid = s2_v_q;
    assign m_axis_vid_tdata = s2_data_q;
    assign m_axis_vid_tuser = s2_user_q;
    assign m_axis_vid_tlast = s2_last_q;
endmodule
